slv_guard_rst_seq: RTL and testbench

// - Consumes rst_req_o from slv_guard_top and sequences recovery of the guarded AXI slave.
// - Sequence: isolate the slave port, hold the slave in reset, let it settle, de-isolate,

---
 rtl/slv_guard_rst_seq.sv | 176 +++++++++++++++++
 tb/tb_slv_guard_rst_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_guard_rst_seq.sv
// slv_guard_rst_seq: recovery sequencer for an AXI slave behind slv_guard_top.
// On a reset request it isolates the slave port, holds the slave in reset,
// lets it settle, de-isolates it, and then pulses a clear back to the guard.
// All outputs are registered and decoded from the next state.
// Optional feature macro SLV_GUARD_RST_SEQ_TIMEOUT_EN bounds the isolate and
// de-isolate handshakes with a drain timer and flags expiry on timeout_o.
// Note: rst_n is an asynchronous, active-HIGH reset despite its name.

module slv_guard_rst_seq #(
    parameter int unsigned RstCycles    = 4,
    parameter int unsigned SettleCycles = 2,
    parameter int unsigned DrainTimeout = 256,
    parameter int unsigned CntWidth     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rst_req_i,
    output logic                isolate_o,
    input  logic                isolated_i,
    output logic                slv_rst_no,
    output logic                guard_clr_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] rst_cnt_o,
    output logic                timeout_o
);

    localparam int unsigned MaxRs  = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int unsigned MaxCnt = (MaxRs > DrainTimeout) ? MaxRs : DrainTimeout;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StIsolate = 3'd1;
    localparam logic [2:0] StReset   = 3'd2;
    localparam logic [2:0] StSettle  = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;
    localparam logic [2:0] StClear   = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                isolate_q, isolate_d;
    logic                slv_rst_n_q, slv_rst_n_d;
    logic                clr_q, clr_d;
    logic                busy_q, busy_d;
    logic [CntWidth-1:0] rst_cnt_q, rst_cnt_d;
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
    logic                timeout_q, timeout_d;
`endif

    // Next-state and cycle counter: a single down-counter is shared by all timed states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            StIdle: begin
                // Requests are only honoured here; anything seen mid-sequence is dropped.
                if (rst_req_i) begin
                    state_d = StIsolate;
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
                    cnt_d = CW'(DrainTimeout - 1);
`endif
                end
            end
            StIsolate: begin
                if (isolated_i) begin
                    state_d = StReset;
                    cnt_d   = CW'(RstCycles - 1);
                end
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    // Drain never completed: reset the slave anyway.
                    state_d   = StReset;
                    cnt_d     = CW'(RstCycles - 1);
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`endif
            end
            StReset: begin
                if (cnt_q == '0) begin
                    state_d = StSettle;
                    cnt_d   = CW'(SettleCycles);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StRelease;
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
                    cnt_d = CW'(DrainTimeout - 1);
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StRelease: begin
                if (!isolated_i) begin
                    state_d = StClear;
                end
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d   = StClear;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`endif
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        isolate_d   = (state_d == StIsolate) || (state_d == StReset) || (state_d == StSettle);
        slv_rst_n_d = (state_d != StReset);
        clr_d       = (state_d == StClear);
        busy_d      = (state_d != StIdle);
        rst_cnt_d   = rst_cnt_q;
        if ((state_d == StClear) && (rst_cnt_q != {CntWidth{1'b1}})) begin
            rst_cnt_d = rst_cnt_q + CntWidth'(1);
        end
    end

    // State, counter and output registers; async reset releases the slave at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            isolate_q   <= 1'b0;
            slv_rst_n_q <= 1'b1;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            rst_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            isolate_q   <= isolate_d;
            slv_rst_n_q <= slv_rst_n_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
    // Sticky drain-timeout flag, cleared only by rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign isolate_o   = isolate_q;
    assign slv_rst_no  = slv_rst_n_q;
    assign guard_clr_o = clr_q;
    assign busy_o      = busy_q;
    assign rst_cnt_o   = rst_cnt_q;

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Directed bench for slv_guard_rst_seq. dut1 uses the nominal timing
// (RstCycles=4, SettleCycles=2); dut2 uses the minimum timing with a 2-bit
// recovery counter and a short drain timeout.

module tb_slv_guard_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       req1, iso1_auto, iso1_man, isolated1;
    logic       isolate1, slv_rst_n1, clr1, busy1, timeout1;
    logic [7:0] cnt1;

    logic       req2, iso2_auto, isolated2;
    logic       isolate2, slv_rst_n2, clr2, busy2, timeout2;
    logic [1:0] cnt2;

    // Isolation stage model: either echoes isolate_o or is forced by the bench.
    assign isolated1 = iso1_auto ? isolate1 : iso1_man;
    assign isolated2 = iso2_auto ? isolate2 : 1'b0;

    slv_guard_rst_seq #(
        .RstCycles   (4),
        .SettleCycles(2),
        .DrainTimeout(64),
        .CntWidth    (8)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_req_i  (req1),
        .isolate_o  (isolate1),
        .isolated_i (isolated1),
        .slv_rst_no (slv_rst_n1),
        .guard_clr_o(clr1),
        .busy_o     (busy1),
        .rst_cnt_o  (cnt1),
        .timeout_o  (timeout1)
    );

    slv_guard_rst_seq #(
        .RstCycles   (1),
        .SettleCycles(0),
        .DrainTimeout(16),
        .CntWidth    (2)
    ) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_req_i  (req2),
        .isolate_o  (isolate2),
        .isolated_i (isolated2),
        .slv_rst_no (slv_rst_n2),
        .guard_clr_o(clr2),
        .busy_o     (busy2),
        .rst_cnt_o  (cnt2),
        .timeout_o  (timeout2)
    );

    // Select which DUT the sequence watcher observes.
    bit         sel;
    logic       w_busy, w_rstn, w_clr, w_iso;
    logic [7:0] w_cnt;
    assign w_busy = sel ? busy2 : busy1;
    assign w_rstn = sel ? slv_rst_n2 : slv_rst_n1;
    assign w_clr  = sel ? clr2 : clr1;
    assign w_iso  = sel ? isolate2 : isolate1;
    assign w_cnt  = sel ? {6'b0, cnt2} : cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v);
        if (sel) req2 = v;
        else req1 = v;
    endtask

    // Run until busy drops (bounded), collecting per-sequence measurements.
    task automatic watch(input int max_cyc, input int drop_at, input int pulse_at,
                         output int cyc, output int low, output int clr,
                         output int first_low, output int overlap);
        cyc = 0; low = 0; clr = 0; first_low = -1; overlap = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            if (i == drop_at) set_req(1'b0);
            if (i == pulse_at) set_req(1'b1);
            if (i == pulse_at + 1) set_req(1'b0);
            if (!w_rstn) begin
                low++;
                if (first_low < 0) first_low = i;
                if (!w_iso) overlap++;
            end
            if (w_clr) clr++;
            if (!w_busy) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc, low, clr, first_low, overlap, cnt, first;
        rst_n = 1'b1; req1 = 1'b0; req2 = 1'b0;
        iso1_auto = 1'b1; iso1_man = 1'b0; iso2_auto = 1'b1; sel = 1'b0;
        repeat (3) step();

        // Reset values
        check_eq("rst_isolate", {31'b0, isolate1}, 0);
        check_eq("rst_slv_rst_n", {31'b0, slv_rst_n1}, 1);
        check_eq("rst_clr", {31'b0, clr1}, 0);
        check_eq("rst_busy", {31'b0, busy1}, 0);
        check_eq("rst_cnt", {24'b0, cnt1}, 0);
        check_eq("rst_timeout", {31'b0, timeout1}, 0);
        rst_n = 1'b0;
        step();
        check_eq("idle_busy", {31'b0, busy1}, 0);

        // Nominal sequence, isolation acknowledged immediately
        req1 = 1'b1;
        watch(40, 1, -1, cyc, low, clr, first_low, overlap);
        check_eq("nom_cycles", cyc, 11);
        check_eq("nom_low_cycles", low, 4);
        check_eq("nom_latency", first_low, 2);
        check_eq("nom_clr_pulses", clr, 1);
        check_eq("nom_rst_while_open", overlap, 0);
        check_eq("nom_cnt", {24'b0, cnt1}, 1);
        check_eq("nom_isolate_after", {31'b0, isolate1}, 0);

        // Request pulsed again during RESET is ignored
        req1 = 1'b1;
        watch(40, 1, 3, cyc, low, clr, first_low, overlap);
        check_eq("busyreq_cycles", cyc, 11);
        check_eq("busyreq_clr_pulses", clr, 1);
        check_eq("busyreq_cnt", {24'b0, cnt1}, 2);
        step();
        check_eq("busyreq_no_restart", {31'b0, busy1}, 0);

        // Request held through CLEAR starts a second sequence
        req1 = 1'b1;
        watch(40, -1, -1, cyc, low, clr, first_low, overlap);
        check_eq("held_cycles", cyc, 11);
        check_eq("held_cnt", {24'b0, cnt1}, 3);
        step();
        check_eq("held_restart_busy", {31'b0, busy1}, 1);
        req1 = 1'b0;
        watch(40, -1, -1, cyc, low, clr, first_low, overlap);
        check_eq("held2_cycles", cyc, 10);
        check_eq("held2_low_cycles", low, 4);
        check_eq("held2_clr_pulses", clr, 1);
        check_eq("held2_cnt", {24'b0, cnt1}, 4);

        // Slow drain: isolation ack withheld for 50 cycles
        iso1_auto = 1'b0; iso1_man = 1'b0;
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        check_eq("drain_isolate", {31'b0, isolate1}, 1);
        low = 0; cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!slv_rst_n1) low++;
            if (busy1) cnt++;
        end
        check_eq("drain_no_reset", low, 0);
        check_eq("drain_busy_cycles", cnt, 50);
        iso1_auto = 1'b1;
        watch(40, -1, -1, cyc, low, clr, first_low, overlap);
        check_eq("drain_cycles", cyc, 10);
        check_eq("drain_low_cycles", low, 4);
        check_eq("drain_clr_pulses", clr, 1);
        check_eq("drain_cnt", {24'b0, cnt1}, 5);
        check_eq("drain_timeout", {31'b0, timeout1}, 0);

        // Asynchronous reset in the middle of RESET
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        step();
        check_eq("mid_in_reset", {31'b0, slv_rst_n1}, 0);
        #2 rst_n = 1'b1;
        #1;
        check_eq("mid_async_rstn", {31'b0, slv_rst_n1}, 1);
        check_eq("mid_async_iso", {31'b0, isolate1}, 0);
        check_eq("mid_async_busy", {31'b0, busy1}, 0);
        check_eq("mid_async_cnt", {24'b0, cnt1}, 0);
        step();
        check_eq("mid_edge_rstn", {31'b0, slv_rst_n1}, 1);
        check_eq("mid_edge_busy", {31'b0, busy1}, 0);
        rst_n = 1'b0;
        step();

        // Minimum timing and counter saturation on the 2-bit DUT
        sel = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            req2 = 1'b1;
            watch(20, 1, -1, cyc, low, clr, first_low, overlap);
            check_eq("sat_cycles", cyc, 6);
            check_eq("sat_low_cycles", low, 1);
            check_eq("sat_clr_pulses", clr, 1);
            check_eq("sat_cnt", {30'b0, cnt2}, (k > 3) ? 3 : k);
        end

        // Isolation ack stuck low
        iso2_auto = 1'b0;
        req2 = 1'b1;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) req2 = 1'b0;
            if (!slv_rst_n2) begin
                first = i;
                break;
            end
        end
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
        check_eq("stuck_first_reset", first, 17);
        check_eq("stuck_timeout", {31'b0, timeout2}, 1);
`else
        check_eq("stuck_first_reset", first, -1);
        check_eq("stuck_timeout", {31'b0, timeout2}, 0);
        check_eq("stuck_busy", {31'b0, busy2}, 1);
`endif
        iso2_auto = 1'b1;
        watch(20, -1, -1, cyc, low, clr, first_low, overlap);
`ifdef SLV_GUARD_RST_SEQ_TIMEOUT_EN
        check_eq("stuck_finish_cycles", cyc, 4);
        check_eq("stuck_timeout_sticky", {31'b0, timeout2}, 1);
`else
        check_eq("stuck_finish_cycles", cyc, 5);
        check_eq("stuck_timeout_sticky", {31'b0, timeout2}, 0);
`endif
        check_eq("stuck_cnt", {30'b0, cnt2}, 3);
        check_eq("dut1_timeout_end", {31'b0, timeout1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
